// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes opcode/funct into the 3-bit ALU select, sequences
// single-cycle ops and the multi-cycle MOD unit, and returns a registered result
// with zero/error flags. Issue stalls (instr_ready=0) while an op is in flight.
module alu_issue_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MOD_TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic [2:0]       alu_ctr,
  output logic             mod_start,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             mod_done,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_err
);

  // Counter only needs to reach MOD_TIMEOUT-1.
  localparam int CW = (MOD_TIMEOUT > 2) ? $clog2(MOD_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MOD_TIMEOUT - 1);

  // ALU operation codes
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_EXEC      = 2'd1,
    S_MOD_START = 2'd2,
    S_MOD_WAIT  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            dec_legal;
  logic [2:0]      dec_ctr;
  logic            dec_is_mod;
  logic            timeout;

  assign accept     = instr_valid & instr_ready;
  assign dec_is_mod = dec_legal && (dec_ctr == OP_MOD);
  // Done has priority over the timeout when both land on the same cycle.
  assign timeout    = (state == S_MOD_WAIT) && !mod_done && (cnt == CNT_LAST);

  // Instruction decode: opcode/funct -> ALU select plus legality
  always_comb begin
    dec_legal = 1'b1;
    dec_ctr   = OP_AND;
    if (opcode == 6'h00) begin
      unique case (funct)
        6'h24:   dec_ctr = OP_AND;
        6'h25:   dec_ctr = OP_OR;
        6'h26:   dec_ctr = OP_XOR;
        6'h27:   dec_ctr = OP_NOR;
        6'h2A:   dec_ctr = OP_SLT;
        6'h20:   dec_ctr = OP_ADD;
        6'h22:   dec_ctr = OP_SUB;
        6'h1A:   dec_ctr = OP_MOD;
        default: dec_legal = 1'b0;
      endcase
    end else begin
      unique case (opcode)
        6'h08, 6'h23, 6'h2B: dec_ctr = OP_ADD;
        6'h0C:               dec_ctr = OP_AND;
        6'h0D:               dec_ctr = OP_OR;
        6'h0A:               dec_ctr = OP_SLT;
        6'h04:               dec_ctr = OP_SUB;
        default:             dec_legal = 1'b0;
      endcase
    end
  end

  // State register
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next-state logic; illegal ops never leave IDLE
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept && dec_legal) state_n = dec_is_mod ? S_MOD_START : S_EXEC;
      end
      S_EXEC:      state_n = S_IDLE;
      S_MOD_START: state_n = S_MOD_WAIT;
      S_MOD_WAIT:  if (mod_done || timeout) state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    instr_ready = (state == S_IDLE);
    mod_start   = (state == S_MOD_START);
  end

  // ALU select: loaded only on a legal accept, held otherwise
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)                             alu_ctr <= OP_AND;
    else if (accept && dec_legal)             alu_ctr <= dec_ctr;
  end

  // Wait counter for the modulo unit: cleared while launching, counts every wait cycle
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)                      cnt <= '0;
    else if (state == S_MOD_START)     cnt <= '0;
    else if (state == S_MOD_WAIT)      cnt <= cnt + 1'b1;
  end

  // Result capture and one-cycle res_valid pulse
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept && !dec_legal) begin
            res_valid <= 1'b1;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_err   <= 1'b1;
          end
        end
        S_EXEC: begin
          res_valid <= 1'b1;
          res_data  <= alu_result;
          res_zero  <= alu_zero;
          res_err   <= 1'b0;
        end
        S_MOD_WAIT: begin
          if (mod_done) begin
            res_valid <= 1'b1;
            res_data  <= alu_result;
            res_zero  <= alu_zero;
            res_err   <= 1'b0;
          end else if (timeout) begin
            res_valid <= 1'b1;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed steps, an ALU stand-in driven from alu_ctr,
// and a result scoreboard popped on every res_valid pulse.
module tb_alu_issue_ctrl;

  localparam int WIDTH = 32;
  localparam int TO    = 16;

  logic             CLK;
  logic             reset_n;
  logic             instr_valid;
  logic             instr_ready;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [2:0]       alu_ctr;
  logic             mod_start;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             mod_done;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_err;

  logic [WIDTH-1:0] a, b, mod_res;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             err;
  } exp_t;

  typedef struct {
    logic [5:0]       op;
    logic [5:0]       fn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ctr;
    logic [WIDTH-1:0] res;
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   rv_count = 0;
  int   ms_count = 0;

  alu_issue_ctrl #(.WIDTH(WIDTH), .MOD_TIMEOUT(TO)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct(funct),
    .alu_ctr(alu_ctr), .mod_start(mod_start),
    .alu_result(alu_result), .alu_zero(alu_zero), .mod_done(mod_done),
    .res_valid(res_valid), .res_data(res_data), .res_zero(res_zero), .res_err(res_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ALU stand-in: combinational from alu_ctr, MOD result supplied by the bench
  always_comb begin
    case (alu_ctr)
      3'b000:  alu_result = a & b;
      3'b001:  alu_result = a | b;
      3'b010:  alu_result = a ^ b;
      3'b011:  alu_result = ~(a | b);
      3'b100:  alu_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101:  alu_result = a + b;
      3'b110:  alu_result = a - b;
      default: alu_result = mod_res;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every res_valid pulse must match the oldest pending expectation
  always @(negedge CLK) begin
    if (mod_start) ms_count++;
    if (res_valid) begin
      rv_count++;
      if (q.size() == 0) begin
        chk("unexpected_res_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_data", 64'(res_data), 64'(e.data));
        chk("res_zero", 64'(res_zero), 64'(e.zero));
        chk("res_err",  64'(res_err),  64'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
    int n;
    n = 0;
    while (!instr_ready && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    chk("issue_ready", 64'(instr_ready), 64'd1);
    opcode = op; funct = fn; a = aa; b = bb; instr_valid = 1'b1;
    @(posedge CLK); #1;
    instr_valid = 1'b0;
  endtask

  initial begin
    vec_t tbl[10];
    int   n, ms0, rv0;
    logic rdy_bad;

    tbl[0] = '{6'h00, 6'h24, 32'h0000F0F0, 32'h0000FF00, 3'b000, 32'h0000F000};
    tbl[1] = '{6'h00, 6'h25, 32'h0000F0F0, 32'h0000FF00, 3'b001, 32'h0000FFF0};
    tbl[2] = '{6'h00, 6'h26, 32'h0000F0F0, 32'h0000FF00, 3'b010, 32'h00000FF0};
    tbl[3] = '{6'h00, 6'h27, 32'hFFFF0000, 32'h0000FFFF, 3'b011, 32'h00000000};
    tbl[4] = '{6'h00, 6'h2A, 32'hFFFFFFFF, 32'h00000001, 3'b100, 32'h00000001};
    tbl[5] = '{6'h08, 6'h00, 32'd7,        32'd8,        3'b101, 32'd15};
    tbl[6] = '{6'h23, 6'h3F, 32'h00000100, 32'd4,        3'b101, 32'h00000104};
    tbl[7] = '{6'h2B, 6'h00, 32'h00000200, 32'd8,        3'b101, 32'h00000208};
    tbl[8] = '{6'h0A, 6'h00, 32'd5,        32'd3,        3'b100, 32'd0};
    tbl[9] = '{6'h04, 6'h00, 32'd9,        32'd9,        3'b110, 32'd0};

    reset_n = 1'b0; instr_valid = 1'b0; opcode = '0; funct = '0;
    a = '0; b = '0; mod_res = '0; mod_done = 1'b0;
    #2;
    chk("rst_alu_ctr",   64'(alu_ctr),     64'd0);
    chk("rst_res_valid", 64'(res_valid),   64'd0);
    chk("rst_res_data",  64'(res_data),    64'd0);
    chk("rst_res_zero",  64'(res_zero),    64'd0);
    chk("rst_res_err",   64'(res_err),     64'd0);
    chk("rst_mod_start", 64'(mod_start),   64'd0);
    chk("rst_ready",     64'(instr_ready), 64'd1);
    @(posedge CLK); @(posedge CLK); #1;
    reset_n = 1'b1;
    @(posedge CLK); #1;

    // 1: ADD 45+45, two-edge latency
    q.push_back('{32'd90, 1'b0, 1'b0});
    issue(6'h00, 6'h20, 32'd45, 32'd45);
    chk("t1_alu_ctr", 64'(alu_ctr), 64'd5);
    chk("t1_rv_early", 64'(res_valid), 64'd0);
    @(posedge CLK); #1;
    chk("t1_rv_lat", 64'(res_valid), 64'd1);

    // 2: SUB 30-30, issued in the res_valid cycle
    q.push_back('{32'd0, 1'b1, 1'b0});
    issue(6'h00, 6'h22, 32'd30, 32'd30);
    chk("t2_alu_ctr", 64'(alu_ctr), 64'd6);

    // decode table, back-to-back
    foreach (tbl[i]) begin
      q.push_back('{tbl[i].res, (tbl[i].res == '0), 1'b0});
      issue(tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b);
      chk($sformatf("tbl%0d_alu_ctr", i), 64'(alu_ctr), 64'(tbl[i].ctr));
    end
    @(posedge CLK); #1;

    // 3: MOD completing after 10 cycles, result 0
    q.push_back('{32'd0, 1'b1, 1'b0});
    mod_res = 32'd0;
    ms0 = ms_count;
    issue(6'h00, 6'h1A, 32'd35, 32'd7);
    chk("t3_alu_ctr", 64'(alu_ctr), 64'd7);
    chk("t3_mod_start", 64'(mod_start), 64'd1);
    rdy_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      if (instr_ready) rdy_bad = 1'b1;
    end
    chk("t3_ready_low", 64'(rdy_bad), 64'd0);
    chk("t3_rv_before_done", 64'(res_valid), 64'd0);
    mod_done = 1'b1;
    @(posedge CLK); #1;
    mod_done = 1'b0;
    chk("t3_rv", 64'(res_valid), 64'd1);
    chk("t3_start_pulses", 64'(ms_count - ms0), 64'd1);
    @(posedge CLK); #1;
    chk("t3_rv_one_cycle", 64'(res_valid), 64'd0);

    // 4: MOD with no done -> timeout error, then andi accepted
    q.push_back('{32'd0, 1'b0, 1'b1});
    mod_res = 32'd5;
    issue(6'h00, 6'h1A, 32'd0, 32'd0);
    n = 0;
    while (!res_valid && n < 200) begin
      @(posedge CLK); #1; n++;
    end
    chk("t4_timeout_edges", 64'(n), 64'(TO + 1));
    q.push_back('{32'h30, 1'b0, 1'b0});
    issue(6'h0C, 6'h00, 32'hF0, 32'h3C);
    chk("t4_next_alu_ctr", 64'(alu_ctr), 64'd0);
    @(posedge CLK); #1;

    // 5: illegal opcode, then ori straight after
    q.push_back('{32'd0, 1'b0, 1'b1});
    issue(6'h3F, 6'h00, 32'd1, 32'd2);
    chk("t5_rv", 64'(res_valid), 64'd1);
    chk("t5_alu_ctr_held", 64'(alu_ctr), 64'd0);
    q.push_back('{32'hFF, 1'b0, 1'b0});
    issue(6'h0D, 6'h00, 32'h0F, 32'hF0);
    chk("t5_ori_alu_ctr", 64'(alu_ctr), 64'd1);
    @(posedge CLK); @(posedge CLK); #1;

    // illegal funct under opcode 0
    q.push_back('{32'd0, 1'b0, 1'b1});
    issue(6'h00, 6'h21, 32'd1, 32'd2);
    chk("illegal_funct_ctr_held", 64'(alu_ctr), 64'd1);
    @(posedge CLK); @(posedge CLK); #1;

    // 6: async reset during MOD_WAIT; a late done must not produce a result
    q.push_back('{32'h77, 1'b0, 1'b0});
    issue(6'h00, 6'h25, 32'h70, 32'h07);
    @(posedge CLK); #1;
    mod_res = 32'h1234;
    issue(6'h00, 6'h1A, 32'd0, 32'd0);
    @(posedge CLK); @(posedge CLK); #3;
    rv0 = rv_count;
    reset_n = 1'b0;
    #1;
    chk("t6_alu_ctr",   64'(alu_ctr),     64'd0);
    chk("t6_res_data",  64'(res_data),    64'd0);
    chk("t6_res_valid", 64'(res_valid),   64'd0);
    chk("t6_res_err",   64'(res_err),     64'd0);
    chk("t6_ready",     64'(instr_ready), 64'd1);
    @(negedge CLK);
    reset_n = 1'b1;
    mod_done = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    mod_done = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("t6_no_late_rv", 64'(rv_count - rv0), 64'd0);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
